// File: rtl/plca_param.sv
// plca_param -- shared definitions for the PLCA control scheduler.
//   plca_state_t : FSM state encoding (also exported on plca_state for debug)
//   CMD_*        : PCS command codes, shared by rx_cmd and tx_cmd
//   NODE_ID_OFF  : local_nodeID value that switches PLCA off
//   sat_inc8     : 8-bit saturating increment used for curID
package plca_param;

   typedef enum logic [3:0] {
      ST_DISABLE     = 4'd0,
      ST_RESYNC      = 4'd1,
      ST_SEND_BEACON = 4'd2,
      ST_SYNCING     = 4'd3,
      ST_WAIT_TO     = 4'd4,
      ST_COMMIT      = 4'd5,
      ST_TRANSMIT    = 4'd6,
      ST_BURST       = 4'd7,
      ST_RECEIVE     = 4'd8,
      ST_NEXT_TX_OPP = 4'd9
   } plca_state_t;

   localparam logic [1:0] CMD_NONE      = 2'd0;
   localparam logic [1:0] CMD_COMMIT    = 2'd1;
   localparam logic [1:0] CMD_HEARTBEAT = 2'd2;
   localparam logic [1:0] CMD_BEACON    = 2'd3;

   localparam logic [7:0] NODE_ID_OFF = 8'hFF;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/plca_timer.sv
// plca_timer -- clear/expire cycle counter.
//   clk     : clock
//   rst     : synchronous active-high reset
//   clear   : hold count at 0 (the owning state is not active)
//   expired : count has reached LIMIT-1; the counter then holds there
// The count is 0 in the first cycle after clear drops, so expired rises
// in the LIMIT-th cycle of the owning state.
module plca_timer #(
   parameter int LIMIT = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic expired
);

   localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear)      cnt <= '0;
      else if (cnt != LAST)  cnt <= cnt + 1'b1;
   end

   assign expired = (cnt == LAST);

endmodule

// File: rtl/plca_control.sv
// plca_control -- PLCA transmit-opportunity scheduler for a 10BASE-T1S node.
//   clk, plca_reset          : clock, synchronous active-high reset
//   plca_en, local_nodeID    : enable; ID 255 turns PLCA off
//   node_count, max_bc       : cycle length (node 0), extra frames per opportunity
//   rx_cmd, CRS              : PCS receive command and carrier sense
//   packet_pending, tx_done  : MAC request and end-of-frame pulse
//   tx_cmd, tx_grant         : PCS transmit command, MAC transmit permission
//   curID, bc, plca_status   : opportunity owner, burst count, beacon sync
//   plca_state               : state encoding for debug
// All outputs are registered from the next-state decision, so a state's
// outputs are visible during the cycles the FSM sits in that state.
// curID advances on leaving NEXT_TX_OPPORTUNITY, so the new owner is
// already valid in the first WAIT_TO cycle of its opportunity.
module plca_control
   import plca_param::*;
#(
   parameter int TO_CYCLES      = 32,
   parameter int BEACON_CYCLES  = 20,
   parameter int BURST_CYCLES   = 128,
   parameter int BEACON_TIMEOUT = 4000
) (
   input  logic       clk,
   input  logic       plca_reset,
   input  logic       plca_en,
   input  logic [7:0] local_nodeID,
   input  logic [7:0] node_count,
   input  logic [7:0] max_bc,
   input  logic [1:0] rx_cmd,
   input  logic       CRS,
   input  logic       packet_pending,
   input  logic       tx_done,
   output logic [1:0] tx_cmd,
   output logic       tx_grant,
   output logic [7:0] curID,
   output logic [7:0] bc,
   output logic       plca_status,
   output logic [3:0] plca_state
);

   plca_state_t state, nxt;

   logic is_node0, disabled, bcn_rx, bcn_pend;
   logic to_exp, bcn_len_exp, burst_exp, bcn_tmo_exp, bcn_clr, bcn_tmo;
   logic last_opp;

   assign is_node0 = (local_nodeID == 8'd0);
   assign disabled = !plca_en || (local_nodeID == NODE_ID_OFF);
   assign bcn_rx   = (rx_cmd == CMD_BEACON);

   // node 0 closes the cycle once the following ID would be out of range;
   // 9-bit sum so curID=255 cannot wrap
   assign last_opp = ({1'b0, curID} + 9'd1) >= {1'b0, node_count};

   // beacon watchdog only runs on followers that believe they are synced
   assign bcn_clr = is_node0 || (state == ST_DISABLE) ||
                    (state == ST_RESYNC) || (state == ST_SYNCING);
   assign bcn_tmo = bcn_tmo_exp && !bcn_clr;

   plca_timer #(.LIMIT(TO_CYCLES)) u_to_tmr (
      .clk(clk), .rst(plca_reset), .clear(state != ST_WAIT_TO), .expired(to_exp));

   plca_timer #(.LIMIT(BEACON_CYCLES)) u_bcn_len (
      .clk(clk), .rst(plca_reset), .clear(state != ST_SEND_BEACON), .expired(bcn_len_exp));

   plca_timer #(.LIMIT(BURST_CYCLES)) u_burst_tmr (
      .clk(clk), .rst(plca_reset), .clear(state != ST_BURST), .expired(burst_exp));

   plca_timer #(.LIMIT(BEACON_TIMEOUT)) u_bcn_tmo (
      .clk(clk), .rst(plca_reset), .clear(bcn_clr), .expired(bcn_tmo_exp));

   always_ff @(posedge clk) begin
      if (plca_reset) state <= ST_DISABLE;
      else            state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         ST_DISABLE:     nxt = ST_RESYNC;
         ST_RESYNC: begin
            if (is_node0) begin
               if (!CRS) nxt = ST_SEND_BEACON;
            end else if (bcn_rx) begin
               nxt = ST_SYNCING;
            end
         end
         ST_SEND_BEACON: if (bcn_len_exp) nxt = ST_SYNCING;
         ST_SYNCING:     if (is_node0 || !bcn_rx) nxt = ST_WAIT_TO;
         ST_WAIT_TO: begin
            if (curID == local_nodeID && packet_pending) nxt = ST_COMMIT;
            else if (CRS)                                nxt = ST_RECEIVE;
            // a follower parked at ID 255 waits here for the next beacon
            else if (to_exp && (is_node0 || curID != 8'hFF)) nxt = ST_NEXT_TX_OPP;
         end
         ST_COMMIT:      nxt = ST_TRANSMIT;
         ST_TRANSMIT: begin
            if (tx_done) begin
               if (!is_node0 && (bcn_pend || bcn_rx))    nxt = ST_SYNCING;
               else if (packet_pending && bc < max_bc)   nxt = ST_BURST;
               else                                      nxt = ST_NEXT_TX_OPP;
            end
         end
         ST_BURST: begin
            if (packet_pending) nxt = ST_TRANSMIT;
            else if (burst_exp) nxt = ST_NEXT_TX_OPP;
         end
         ST_RECEIVE:     if (!CRS) nxt = ST_NEXT_TX_OPP;
         ST_NEXT_TX_OPP: nxt = (is_node0 && last_opp) ? ST_SEND_BEACON : ST_WAIT_TO;
         default:        nxt = ST_DISABLE;
      endcase

      // follower resync events; a beacon seen mid-frame is deferred above
      if (!is_node0 && state != ST_DISABLE && state != ST_RESYNC) begin
         if (bcn_rx && state != ST_TRANSMIT) nxt = ST_SYNCING;
         else if (bcn_tmo)                   nxt = ST_RESYNC;
      end

      if (disabled) nxt = ST_DISABLE;
   end

   always_ff @(posedge clk) begin
      if (plca_reset) begin
         tx_cmd      <= CMD_NONE;
         tx_grant    <= 1'b0;
         curID       <= 8'd0;
         bc          <= 8'd0;
         plca_status <= 1'b0;
         bcn_pend    <= 1'b0;
      end else begin
         tx_grant <= (nxt == ST_TRANSMIT);
         bcn_pend <= (state == ST_TRANSMIT) && !is_node0 && (bcn_pend || bcn_rx);

         if (nxt == ST_SEND_BEACON)                    tx_cmd <= CMD_BEACON;
         else if (nxt == ST_COMMIT || nxt == ST_BURST) tx_cmd <= CMD_COMMIT;
         else                                          tx_cmd <= CMD_NONE;

         if (nxt == ST_DISABLE) begin
            curID       <= 8'd0;
            bc          <= 8'd0;
            plca_status <= 1'b0;
         end else begin
            if (nxt == ST_SYNCING) begin
               curID       <= 8'd0;
               plca_status <= 1'b1;
            end else begin
               if (nxt == ST_RESYNC)         plca_status <= 1'b0;
               if (state == ST_NEXT_TX_OPP)  curID <= sat_inc8(curID);
            end

            if (nxt == ST_COMMIT)                              bc <= 8'd0;
            else if (state == ST_TRANSMIT && nxt == ST_BURST)  bc <= bc + 8'd1;
         end
      end
   end

   assign plca_state = state;

endmodule
